// File: rtl/fir_mac_param_if.sv
// Sample/coefficient/result bundle for fir_mac_param.
// The filter uses the slave side; a sample source or bench uses the master side.
interface fir_mac_param_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 18
);
    // Sample handshake: a sample on 'a' moves only on a rising edge where
    // in_valid and in_ready are both 1. The source holds 'a' while in_valid=1
    // and in_ready=0. out_valid is a one-cycle pulse marking a new 'y'.
    logic [DATA_W-1:0] a;
    logic              in_valid;
    logic              in_ready;
    logic              shift_en;
    logic              shift_in;
    logic              coef_load;
    logic [OUT_W-1:0]  y;
    logic              out_valid;
    logic              coef_pending;
    logic [1:0]        state;

    modport slave (
        input  a, in_valid, shift_en, shift_in, coef_load,
        output in_ready, y, out_valid, coef_pending, state
    );

    modport master (
        output a, in_valid, shift_en, shift_in, coef_load,
        input  in_ready, y, out_valid, coef_pending, state
    );
endinterface

// File: rtl/fir_mac_param.sv
// TAPS-tap unsigned FIR filter built around a single time-multiplexed MAC.
// Coefficients are loaded serially into a shadow chain and committed atomically in IDLE.
module fir_mac_param #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 4,
    parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic            ph1,
    input  logic            reset,
    fir_mac_param_if.slave  bus
);

    localparam int K_W  = $clog2(TAPS);
    localparam int P_W  = DATA_W + COEF_W;
    localparam int SH_W = TAPS * COEF_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   x_q [TAPS];
    logic [DATA_W-1:0]   x_d [TAPS];
    logic [COEF_W-1:0]   c_q [TAPS];
    logic [COEF_W-1:0]   c_d [TAPS];
    logic [SH_W-1:0]     shadow_q, shadow_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [OUT_W-1:0]    y_q, y_d;
    logic [K_W-1:0]      k_q, k_d;
    logic                pend_q, pend_d;

    logic                in_ready_s;
    logic                out_valid_s;
    logic                accept;
    logic                last_tap;
    logic                commit;
    logic [P_W-1:0]      prod;
    logic [OUT_W-1:0]    acc_sum;

    assign accept   = bus.in_valid & in_ready_s;
    assign last_tap = (state_q == S_MAC) && (k_q == K_W'(TAPS - 1));
    // A pending or same-cycle load commits only in IDLE, so an in-flight sum keeps its coefficients.
    assign commit   = (state_q == S_IDLE) && (pend_q || bus.coef_load);

    assign prod     = P_W'(c_q[k_q]) * P_W'(x_q[k_q]);
    assign acc_sum  = acc_q + OUT_W'(prod);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_MAC;
            S_MAC:   if (last_tap) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_q)
            S_IDLE:  in_ready_s  = 1'b1;
            S_DONE:  out_valid_s = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath next-state ----------------
    always_comb begin
        shadow_d = shadow_q;
        if (bus.shift_en) begin
            shadow_d = {shadow_q[SH_W-2:0], bus.shift_in};
        end

        pend_d = pend_q;
        if (state_q == S_IDLE) begin
            pend_d = 1'b0;
        end else if (bus.coef_load) begin
            pend_d = 1'b1;
        end

        for (int i = 0; i < TAPS; i++) begin
            c_d[i] = commit ? shadow_q[i*COEF_W +: COEF_W] : c_q[i];
        end

        for (int i = 0; i < TAPS; i++) begin
            x_d[i] = x_q[i];
        end
        if (accept) begin
            x_d[0] = bus.a;
            for (int i = 1; i < TAPS; i++) begin
                x_d[i] = x_q[i-1];
            end
        end

        acc_d = acc_q;
        k_d   = k_q;
        y_d   = y_q;
        if (accept) begin
            acc_d = '0;
            k_d   = '0;
        end else if (state_q == S_MAC) begin
            acc_d = acc_sum;
            k_d   = k_q + K_W'(1);
            // y takes the final sum as DONE is entered, so it is new while out_valid is high.
            if (last_tap) begin
                y_d = acc_sum;
            end
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            pend_q   <= 1'b0;
            acc_q    <= '0;
            k_q      <= '0;
            y_q      <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            y_q      <= y_d;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= x_d[i];
                c_q[i] <= c_d[i];
            end
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_s;
    assign bus.y            = y_q;
    assign bus.coef_pending = pend_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_fir_mac_param.sv
// Directed bench for fir_mac_param: reset, coefficient loads, latency, overflow
// boundary, deferred commit, back-to-back handshake and reset mid-sum.
module tb_fir_mac_param;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int TAPS   = 4;
    localparam int OUT_W  = 18;

    logic ph1   = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;

    // Handshake-section state
    logic [7:0]  hs_s   [5];
    logic [31:0] hs_exp [5];
    int          hs_idx;
    int          hs_res;
    int          hs_cyc;
    int          hs_last;
    int          hs_dbl;
    logic        hs_prev_ov;
    int          ov_seen;

    fir_mac_param_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    fir_mac_param #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .TAPS  (TAPS),
        .OUT_W (OUT_W)
    ) dut (
        .ph1  (ph1),
        .reset(reset),
        .bus  (bus)
    );

    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic shift_coefs(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            bus.shift_en = 1'b1;
            bus.shift_in = v[i];
            @(negedge ph1);
        end
        bus.shift_en = 1'b0;
        bus.shift_in = 1'b0;
    endtask

    task automatic pulse_load();
        bus.coef_load = 1'b1;
        @(negedge ph1);
        bus.coef_load = 1'b0;
    endtask

    task automatic start_sample(input logic [7:0] s);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge ph1);
            n++;
        end
        check("in_ready_before_send", bus.in_ready, 1);
        bus.a        = s;
        bus.in_valid = 1'b1;
        @(negedge ph1);
        bus.in_valid = 1'b0;
    endtask

    // cyc0 = index of the current cycle after acceptance (1 = first cycle after the accept edge)
    task automatic wait_result(input string tag, input int cyc0, input logic [31:0] exp_y);
        int cyc;
        cyc = cyc0;
        while (bus.out_valid !== 1'b1 && cyc < 20) begin
            @(negedge ph1);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 5);
        check({tag, "_y"}, bus.y, exp_y);
        @(negedge ph1);
        check({tag, "_pulse_width"}, bus.out_valid, 0);
    endtask

    task automatic send(input logic [7:0] s, input string tag, input logic [31:0] exp_y);
        start_sample(s);
        wait_result(tag, 1, exp_y);
    endtask

    initial begin
        bus.a         = '0;
        bus.in_valid  = 1'b0;
        bus.shift_en  = 1'b0;
        bus.shift_in  = 1'b0;
        bus.coef_load = 1'b0;

        // ---- Reset ----
        reset = 1'b0;
        repeat (3) @(posedge ph1);
        @(negedge ph1);
        check("rst_hold_y", bus.y, 0);
        check("rst_hold_out_valid", bus.out_valid, 0);
        reset = 1'b1;
        @(negedge ph1);
        check("rst_y", bus.y, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_coef_pending", bus.coef_pending, 0);
        check("rst_state", bus.state, 0);

        // ---- Coefficient load c3..c0 = 4,3,2,1 ----
        shift_coefs(32'h04030201);
        pulse_load();
        check("load_pending_clear", bus.coef_pending, 0);
        send(8'd10, "load_s10", 10);
        send(8'd20, "load_s20", 40);
        send(8'd30, "load_s30", 100);
        send(8'd40, "load_s40", 200);

        // ---- Overflow boundary: all coefficients 255, line starts 40,30,20,10 ----
        shift_coefs(32'hFFFFFFFF);
        pulse_load();
        send(8'd255, "ovf_1", 87975);
        send(8'd255, "ovf_2", 147900);
        send(8'd255, "ovf_3", 205275);
        send(8'd255, "ovf_4", 260100);

        // ---- Deferred load ----
        reset = 1'b0;
        repeat (3) @(negedge ph1);
        reset = 1'b1;
        @(negedge ph1);
        shift_coefs(32'h04030201);
        pulse_load();
        send(8'd10, "def_pre10", 10);
        send(8'd20, "def_pre20", 40);
        shift_coefs(32'h01010101);
        start_sample(8'd30);
        bus.coef_load = 1'b1;
        @(negedge ph1);
        bus.coef_load = 1'b0;
        check("def_pending_mac", bus.coef_pending, 1);
        check("def_in_ready_mac", bus.in_ready, 0);
        wait_result("def_old_coefs", 2, 100);
        check("def_pending_first_idle", bus.coef_pending, 1);
        @(negedge ph1);
        check("def_pending_after_commit", bus.coef_pending, 0);
        send(8'd40, "def_new_coefs", 100);

        // ---- Handshake: in_valid held high, coefficients all 1 ----
        hs_s[0] = 8'd1; hs_s[1] = 8'd2; hs_s[2] = 8'd3; hs_s[3] = 8'd4; hs_s[4] = 8'd5;
        hs_exp[0] = 91; hs_exp[1] = 73; hs_exp[2] = 46; hs_exp[3] = 10; hs_exp[4] = 14;
        hs_idx = 0; hs_res = 0; hs_cyc = 0; hs_last = -1; hs_dbl = 0; hs_prev_ov = 1'b0;
        while (hs_res < 5 && hs_cyc < 100) begin
            if (bus.out_valid === 1'b1) begin
                check("hs_y", bus.y, hs_exp[hs_res]);
                if (hs_prev_ov) hs_dbl++;
                hs_res++;
            end
            hs_prev_ov = bus.out_valid;
            if (bus.in_ready === 1'b1) begin
                if (hs_idx < 5) begin
                    if (hs_last >= 0) check("hs_accept_gap", hs_cyc - hs_last, 6);
                    hs_last      = hs_cyc;
                    bus.a        = hs_s[hs_idx];
                    bus.in_valid = 1'b1;
                    hs_idx++;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge ph1);
            hs_cyc++;
        end
        bus.in_valid = 1'b0;
        check("hs_results", hs_res, 5);
        check("hs_accepts", hs_idx, 5);
        check("hs_double_pulse", hs_dbl, 0);

        // ---- Reset two cycles into MAC ----
        start_sample(8'd9);
        @(negedge ph1);
        reset = 1'b0;
        #1;
        check("midrst_y", bus.y, 0);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_state", bus.state, 0);
        repeat (2) @(negedge ph1);
        reset = 1'b1;
        ov_seen = 0;
        repeat (8) begin
            if (bus.out_valid === 1'b1) ov_seen++;
            @(negedge ph1);
        end
        check("midrst_no_pulse", ov_seen, 0);
        check("midrst_y_after", bus.y, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_pending", bus.coef_pending, 0);
        shift_coefs(32'h04030201);
        pulse_load();
        send(8'd7, "midrst_next", 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
